// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain: read-side drain of the async FIFO into a valid/ready stream.
// Absorbs the one-cycle FIFO read latency with a 3-entry in-order buffer.
module fifo_rd_drain #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  rclk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  empty,
  output logic                  ren,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  rd_count
);

  logic [1:0]            occ;
  logic [1:0]            occ_nxt;
  logic                  inflight;
  logic                  run;
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [DATA_WIDTH-1:0] mem [0:2];
  logic [2:0]            pending;
  logic                  capture;
  logic                  pop;

  function automatic logic [1:0] inc3(
    input logic [1:0] p
  );
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Reserve a slot for every word already requested so capture never overflows.
  assign pending = {1'b0, occ} + {2'b00, inflight};
  assign ren     = run & en & ~empty & (pending < 3'd3);
  assign capture = inflight;
  assign m_valid = (occ != 2'd0);
  assign m_data  = mem[rd_ptr];
  assign pop     = m_valid & m_ready;

  always_comb begin
    occ_nxt = occ;
    unique case ({capture, pop})
      2'b10:   occ_nxt = occ + 2'd1;
      2'b01:   occ_nxt = occ - 2'd1;
      default: occ_nxt = occ;
    endcase
  end

  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      run      <= 1'b0;
      inflight <= 1'b0;
      occ      <= 2'd0;
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      rd_count <= '0;
    end else begin
      run      <= 1'b1;
      inflight <= ren & ~empty;
      occ      <= occ_nxt;
      if (capture) wr_ptr <= inc3(wr_ptr);
      if (pop) begin
        rd_ptr   <= inc3(rd_ptr);
        rd_count <= rd_count + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge rclk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) mem[i] <= '0;
    end else if (capture) begin
      mem[wr_ptr] <= fifo_dout;
    end
  end

  a_no_overflow: assert property (
    @(posedge rclk) disable iff (!rst)
    !(capture && occ == 2'd3)
  );

endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb_fifo_rd_drain: randomized and directed checks of fifo_rd_drain
// against a queue-based reference model and a 1-cycle-latency FIFO model.
module tb_fifo_rd_drain;
  localparam int DW = 32;

  logic          rclk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          empty = 1'b1;
  logic          m_ready = 1'b0;
  logic [DW-1:0] fifo_dout = '0;
  logic          ren, ren_w;
  logic          m_valid, m_valid_w;
  logic [DW-1:0] m_data, m_data_w;
  logic [15:0]   rd_count;
  logic [3:0]    rd_count_w;

  int checks = 0;
  int errors = 0;

  always #5 rclk = ~rclk;

  fifo_rd_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(16)) dut (
    .rclk(rclk), .rst(rst), .en(en), .empty(empty), .ren(ren),
    .fifo_dout(fifo_dout), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .rd_count(rd_count)
  );

  fifo_rd_drain #(.DATA_WIDTH(DW), .CNT_WIDTH(4)) dut_w (
    .rclk(rclk), .rst(rst), .en(en), .empty(empty), .ren(ren_w),
    .fifo_dout(fifo_dout), .m_data(m_data_w), .m_valid(m_valid_w),
    .m_ready(m_ready), .rd_count(rd_count_w)
  );

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] ref_fifo[$];
  logic [DW-1:0] ref_buf[$];
  logic          ref_infl = 1'b0;
  logic [DW-1:0] ref_word = '0;
  logic          ref_run = 1'b0;
  int            ref_cnt = 0;
  logic [DW-1:0] next_val = 32'd1;
  int            cyc = 0;

  logic          obs_ren, obs_valid;
  logic [DW-1:0] obs_data;
  logic [15:0]   obs_cnt;
  logic [3:0]    obs_cnt_w;

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(next_val);
      ref_fifo.push_back(next_val);
      next_val = next_val + 32'd1;
    end
  endtask

  task automatic cycle();
    logic exp_ren, exp_valid, rd_acc;
    logic [DW-1:0] exp_data;
    @(negedge rclk);
    empty = (fifo_q.size() == 0);
    #1;
    obs_ren   = ren;
    obs_valid = m_valid;
    obs_data  = m_data;
    obs_cnt   = rd_count;
    obs_cnt_w = rd_count_w;
    rd_acc    = ren && !empty;
    if (!rst) begin
      ref_buf.delete();
      ref_infl = 1'b0;
      ref_run  = 1'b0;
      ref_cnt  = 0;
    end
    exp_ren = rst && ref_run && en && (ref_fifo.size() != 0) &&
              (ref_buf.size() + int'(ref_infl) < 3);
    exp_valid = (ref_buf.size() != 0);
    exp_data  = exp_valid ? ref_buf[0] : '0;
    checks++;
    if (obs_ren !== exp_ren || ren_w !== exp_ren) begin
      errors++;
      $display("FAIL ren cyc=%0d got %b/%b exp %b", cyc, obs_ren, ren_w, exp_ren);
    end
    checks++;
    if (obs_valid !== exp_valid || m_valid_w !== exp_valid) begin
      errors++;
      $display("FAIL m_valid cyc=%0d got %b/%b exp %b", cyc, obs_valid, m_valid_w, exp_valid);
    end
    if (exp_valid || !rst) begin
      checks++;
      if (obs_data !== exp_data || m_data_w !== exp_data) begin
        errors++;
        $display("FAIL m_data cyc=%0d got %h/%h exp %h", cyc, obs_data, m_data_w, exp_data);
      end
    end
    checks++;
    if (obs_cnt !== 16'(ref_cnt) || obs_cnt_w !== 4'(ref_cnt)) begin
      errors++;
      $display("FAIL rd_count cyc=%0d got %0d/%0d exp %0d", cyc, obs_cnt, obs_cnt_w, ref_cnt);
    end
    if (rst) begin
      if (exp_valid && m_ready) begin
        void'(ref_buf.pop_front());
        ref_cnt++;
      end
      if (ref_infl) ref_buf.push_back(ref_word);
      ref_infl = exp_ren;
      if (exp_ren) ref_word = ref_fifo.pop_front();
      ref_run = 1'b1;
    end
    @(posedge rclk);
    cyc++;
    #1;
    if (rd_acc) fifo_dout = fifo_q.pop_front();
    else fifo_dout = $urandom;
  endtask

  task automatic test_reset();
    en = 1'b1;
    m_ready = 1'b1;
    push_words(1);
    #2 rst = 1'b0;
    repeat (3) cycle();
    checks++;
    if (obs_ren !== 1'b0 || obs_valid !== 1'b0 || obs_data !== '0 || obs_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_vals got ren=%b v=%b d=%h c=%0d exp 0", obs_ren, obs_valid, obs_data, obs_cnt);
    end
    rst = 1'b1;
    cycle();
    checks++;
    if (obs_ren !== 1'b0) begin
      errors++;
      $display("FAIL ren_first_after_release got %b exp 0", obs_ren);
    end
    cycle();
    checks++;
    if (obs_ren !== 1'b1) begin
      errors++;
      $display("FAIL ren_second_after_release got %b exp 1", obs_ren);
    end
  endtask

  task automatic test_single();
    int rc, vc, n_r, n_v;
    logic [DW-1:0] vd;
    rc = cyc - 1;
    vc = -1;
    n_r = 0;
    n_v = 0;
    vd = '0;
    repeat (6) begin
      cycle();
      if (obs_ren) n_r++;
      if (obs_valid) begin
        n_v++;
        vc = cyc - 1;
        vd = obs_data;
      end
    end
    checks++;
    if (n_r != 0 || n_v != 1) begin
      errors++;
      $display("FAIL single_counts got ren=%0d valid=%0d exp 0,1", n_r, n_v);
    end
    checks++;
    if (vc != rc + 2 || vd !== 32'h1) begin
      errors++;
      $display("FAIL single_timing got cyc=%0d data=%h exp cyc=%0d data=1", vc, vd, rc + 2);
    end
    checks++;
    if (obs_cnt !== 16'd1) begin
      errors++;
      $display("FAIL single_count got %0d exp 1", obs_cnt);
    end
  endtask

  task automatic test_streaming();
    logic [DW-1:0] base;
    logic [DW-1:0] got[$];
    int fr, lr, nr, fv, lv;
    base = next_val;
    fr = -1; lr = -1; nr = 0; fv = -1; lv = -1;
    m_ready = 1'b1;
    en = 1'b1;
    push_words(8);
    repeat (14) begin
      cycle();
      if (obs_ren) begin
        if (fr < 0) fr = cyc - 1;
        lr = cyc - 1;
        nr++;
      end
      if (obs_valid) begin
        if (fv < 0) fv = cyc - 1;
        lv = cyc - 1;
        got.push_back(obs_data);
      end
    end
    checks++;
    if (nr != 8 || lr - fr != 7) begin
      errors++;
      $display("FAIL stream_ren got n=%0d span=%0d exp 8,7", nr, lr - fr);
    end
    checks++;
    if (got.size() != 8 || lv - fv != 7) begin
      errors++;
      $display("FAIL stream_valid got n=%0d span=%0d exp 8,7", got.size(), lv - fv);
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== base + 32'(i)) begin
        errors++;
        $display("FAIL stream_data[%0d] got %h exp %h", i, got[i], base + 32'(i));
      end
    end
    checks++;
    if (obs_cnt !== 16'd9) begin
      errors++;
      $display("FAIL stream_count got %0d exp 9", obs_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] base;
    logic [DW-1:0] got[$];
    int nr, unstable, fv, lv;
    base = next_val;
    nr = 0; unstable = 0; fv = -1; lv = -1;
    m_ready = 1'b0;
    en = 1'b1;
    push_words(20);
    repeat (8) begin
      cycle();
      if (obs_ren) nr++;
      if (obs_valid && obs_data !== base) unstable++;
    end
    checks++;
    if (nr != 3 || obs_ren !== 1'b0) begin
      errors++;
      $display("FAIL bp_reads got %0d ren=%b exp 3,0", nr, obs_ren);
    end
    checks++;
    if (obs_valid !== 1'b1 || obs_data !== base || unstable != 0) begin
      errors++;
      $display("FAIL bp_hold got v=%b d=%h bad=%0d exp 1 %h 0", obs_valid, obs_data, unstable, base);
    end
    m_ready = 1'b1;
    repeat (24) begin
      cycle();
      if (obs_valid) begin
        if (fv < 0) fv = cyc - 1;
        lv = cyc - 1;
        got.push_back(obs_data);
      end
    end
    checks++;
    if (got.size() != 20 || lv - fv != 19) begin
      errors++;
      $display("FAIL bp_drain got n=%0d span=%0d exp 20,19", got.size(), lv - fv);
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== base + 32'(i)) begin
        errors++;
        $display("FAIL bp_data[%0d] got %h exp %h", i, got[i], base + 32'(i));
      end
    end
  endtask

  task automatic test_en_drop();
    logic [DW-1:0] base;
    logic [DW-1:0] got[$];
    int bad;
    base = next_val;
    bad = 0;
    m_ready = 1'b1;
    en = 1'b1;
    push_words(10);
    repeat (4) begin
      cycle();
      if (obs_valid) got.push_back(obs_data);
    end
    en = 1'b0;
    repeat (8) begin
      cycle();
      if (obs_ren) bad++;
      if (obs_valid) got.push_back(obs_data);
    end
    checks++;
    if (bad != 0 || obs_valid !== 1'b0 || got.size() != 4) begin
      errors++;
      $display("FAIL en_low got reads=%0d v=%b n=%0d exp 0,0,4", bad, obs_valid, got.size());
    end
    en = 1'b1;
    repeat (16) begin
      cycle();
      if (obs_valid) got.push_back(obs_data);
    end
    checks++;
    if (got.size() != 10) begin
      errors++;
      $display("FAIL en_resume got n=%0d exp 10", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== base + 32'(i)) begin
        errors++;
        $display("FAIL en_data[%0d] got %h exp %h", i, got[i], base + 32'(i));
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [DW-1:0] base;
    logic [DW-1:0] got[$];
    int nr;
    base = next_val;
    nr = 0;
    m_ready = 1'b0;
    en = 1'b1;
    push_words(10);
    for (int k = 0; k < 10 && nr < 3; k++) begin
      cycle();
      if (obs_ren) nr++;
    end
    checks++;
    if (nr != 3) begin
      errors++;
      $display("FAIL mid_reads got %0d exp 3", nr);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || ren !== 1'b0 || rd_count !== 16'd0) begin
      errors++;
      $display("FAIL mid_async got v=%b ren=%b c=%0d exp 0", m_valid, ren, rd_count);
    end
    repeat (2) cycle();
    rst = 1'b1;
    m_ready = 1'b1;
    repeat (20) begin
      cycle();
      if (obs_valid) got.push_back(obs_data);
    end
    checks++;
    if (got.size() != 7) begin
      errors++;
      $display("FAIL mid_resume got n=%0d exp 7", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== base + 32'(i + 3)) begin
        errors++;
        $display("FAIL mid_data[%0d] got %h exp %h", i, got[i], base + 32'(i + 3));
      end
    end
  endtask

  task automatic test_wrap();
    logic h15, h0, h1;
    h15 = 1'b0; h0 = 1'b0; h1 = 1'b0;
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    en = 1'b1;
    m_ready = 1'b1;
    push_words(17);
    repeat (26) begin
      cycle();
      if (obs_cnt_w == 4'd15) h15 = 1'b1;
      else if (h15 && obs_cnt_w == 4'd0) h0 = 1'b1;
      else if (h0 && obs_cnt_w == 4'd1) h1 = 1'b1;
    end
    checks++;
    if (!(h15 && h0 && h1) || obs_cnt_w !== 4'd1) begin
      errors++;
      $display("FAIL wrap_seq got %b%b%b final=%0d exp 111 1", h15, h0, h1, obs_cnt_w);
    end
    checks++;
    if (obs_cnt !== 16'd17) begin
      errors++;
      $display("FAIL wrap_wide got %0d exp 17", obs_cnt);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      en = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 3) == 0) push_words($urandom_range(1, 4));
      cycle();
    end
    rst = 1'b1;
    en = 1'b1;
    m_ready = 1'b1;
    repeat (60) cycle();
    checks++;
    if (obs_valid !== 1'b0 || fifo_q.size() != 0) begin
      errors++;
      $display("FAIL random_drain got v=%b left=%0d exp 0,0", obs_valid, fifo_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_streaming();
    test_backpressure();
    test_en_drop();
    test_reset_midstream();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_rd_drain.md
# fifo_rd_drain

Read-side drain controller for the asynchronous FIFO, running entirely in the read clock domain. It pops words from the FIFO read port, absorbing the FIFO's one-cycle read latency, and presents them to a downstream consumer on a valid/ready stream. A 3-entry holding buffer sustains one word per cycle under continuous ready and tolerates arbitrary backpressure without losing or duplicating data. It also maintains a wrapping count of words delivered.

## Interface
- DATA_WIDTH, 32, width of FIFO data and stream data
- CNT_WIDTH, 16, width of delivered-word counter

- rclk  in  1  read-domain clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- en  in  1  drain enable; when low, no new FIFO reads are issued
- empty  in  1  FIFO empty flag, synchronous to rclk
- ren  out  1  FIFO read enable; combinational
- fifo_dout  in  DATA_WIDTH  FIFO read data, valid the cycle after an accepted read
- m_data  out  DATA_WIDTH  stream data
- m_valid  out  1  stream valid
- m_ready  in  1  stream ready from consumer
- rd_count  out  CNT_WIDTH  words delivered on the stream, wraps modulo 2^CNT_WIDTH

## Operation
- State:
  - occ: buffer occupancy, 0..3.
  - inflight: 1-bit register, set when a read was accepted last cycle.
  - run: 1-bit register, cleared by reset and set on the first rclk edge after rst deasserts.
  - 3-entry in-order buffer.
- ren = run & en & ~empty & (occ + inflight < 3). This is combinational from empty and registered state only; it never depends on m_ready.
- Accepted read: ren & ~empty. It sets inflight for the next cycle.
- Capture: when inflight = 1, fifo_dout is written to the buffer tail on that edge.
- Output: m_valid = (occ != 0). m_data = buffer head.
- Handshake: m_valid & m_ready pops the head and increments rd_count.
- Simultaneous capture and pop in one cycle: occ is unchanged and order is preserved.
- occ + inflight never exceeds 3, so the buffer never overflows. A capture into a full buffer is a design error (add an assertion).
- m_data and m_valid hold stable while m_valid & ~m_ready.
- en low: no new reads are issued. A read already in flight is still captured. The buffer continues to drain normally.
- empty high: ren = 0. No data is assumed from the FIFO.
- Reset asserted at any time:
  - occ = 0, inflight = 0, run = 0.
  - Buffer contents and any in-flight word are discarded.
  - rd_count = 0.
- Reset values: ren 0, m_valid 0, m_data 0, rd_count 0.
- rd_count wraps from 2^CNT_WIDTH-1 to 0 with no flag.

## Timing
- Read latency: ren sampled high at edge E0 → fifo_dout valid after E0 → captured at E1 → m_valid high after E1. First word appears 2 edges after the accepted read.
- Streaming with m_ready = 1 and the FIFO non-empty: steady state occ = 1, inflight = 1. ren stays high every cycle, giving 1 word/cycle throughput.
- Backpressure: ren drops once occ + inflight = 3. After m_ready rises, ren re-asserts in the same cycle that occ + inflight falls below 3.
- rd_count updates on the edge of the handshake and is visible the next cycle.
- ren is 0 in the first cycle after reset release (run = 0) and may assert from the second cycle on.

## Test plan
Bench models the FIFO with 1-cycle read latency, data = incrementing values from 0x0000_0001.
- Reset: hold rst low with empty = 0 and en = 1 → ren = 0, m_valid = 0, m_data = 0, rd_count = 0. Release → ren = 0 for 1 cycle, then 1.
- Single word: FIFO holds 1 word (0x1), m_ready = 1 → one ren pulse. m_valid high exactly 1 cycle, 2 edges after the read, with m_data = 0x1. rd_count = 1.
- Streaming: 8 words, m_ready = 1 → ren high 8 consecutive cycles. m_valid high 8 consecutive cycles with data 0x1..0x8 in order. rd_count = 8.
- Backpressure: 20 words, m_ready = 0 → exactly 3 reads accepted, then ren = 0. m_data = 0x1 held stable. Raise m_ready for 20 cycles → 20 words in order, no gaps after the first, none dropped or duplicated.
- en and reset mid-stream:
  - Drop en during streaming → the word already in flight still delivered, then drain completes; no further reads until en returns.
  - Assert rst while occ = 2 and a read is in flight → all cleared. After release, stream resumes from the next FIFO word.
- Counter wrap: CNT_WIDTH = 4, 17 words → rd_count sequence reaches 15, then 0, then 1.
